ram2_fifo_ctrl: RTL and testbench

Stream-to-RAM FIFO controller that sits directly in front of and behind the `ram2` dual-port memory. It turns a valid/ready input stream into port-A write commands, and issues port-A read commands. It also absorbs the memory's one-cycle registered read latency with a 3-entry output buffer, so the output stream sustains one word per clock. Port B of `ram2` is left to the neighbouring logic.

---
 rtl/ram2_fifo_ctrl.sv | 117 +++++++++++
 tb/tb_ram2_fifo_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram2_fifo_ctrl.sv
// Stream-to-RAM FIFO controller in front of ram2 port A, with a 3-entry output buffer that hides the read latency.
// Optional RAM2_FIFO_CNT_EN adds a registered total-occupancy port fifo_cnt.
module ram2_fifo_ctrl #(
   parameter int unsigned DWIDTH = 16,
   parameter int unsigned AWIDTH = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DWIDTH-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic [DWIDTH-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              wrena,
   output logic [AWIDTH-1:0] wraddra,
   output logic [DWIDTH-1:0] dia,
   output logic              rdena,
   output logic [AWIDTH-1:0] rdaddra,
   input  logic [DWIDTH-1:0] doa,
   output logic              full,
`ifdef RAM2_FIFO_CNT_EN
   output logic [AWIDTH+1:0] fifo_cnt,
`endif
   output logic              empty
);

   localparam logic [AWIDTH:0] DEPTH = {1'b1, {AWIDTH{1'b0}}};

   logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [AWIDTH:0]   ram_cnt_q, ram_cnt_d;
   logic              pipe_v_q, pipe_v_d;
   logic [DWIDTH-1:0] buf_q [3];
   logic [DWIDTH-1:0] buf_d [3];
   logic [1:0]        head_q, head_d;
   logic [1:0]        tail_q, tail_d;
   logic [1:0]        buf_cnt_q, buf_cnt_d;
   logic [2:0]        credit_used;
   logic              pop;

   always_comb begin
      full        = (ram_cnt_q == DEPTH);
      din_ready   = !full;
      wrena       = din_valid & din_ready;
      wraddra     = wr_ptr_q;
      dia         = din;
      // Credit uses registered buf_cnt so a pop never feeds rdena combinationally.
      credit_used = 3'(buf_cnt_q) + 3'(pipe_v_q);
      rdena       = (ram_cnt_q != '0) && (credit_used < 3'd3);
      rdaddra     = rd_ptr_q;
      dout_valid  = (buf_cnt_q != 2'd0);
      dout        = buf_q[head_q];
      pop         = dout_valid & dout_ready;
      empty       = (ram_cnt_q == '0) && !pipe_v_q && (buf_cnt_q == 2'd0);

      wr_ptr_d  = wrena ? wr_ptr_q + AWIDTH'(1) : wr_ptr_q;
      rd_ptr_d  = rdena ? rd_ptr_q + AWIDTH'(1) : rd_ptr_q;
      ram_cnt_d = ram_cnt_q + (AWIDTH+1)'(wrena) - (AWIDTH+1)'(rdena);
      pipe_v_d  = rdena;

      buf_d  = buf_q;
      tail_d = tail_q;
      if (pipe_v_q) begin
         buf_d[tail_q] = doa;
         tail_d        = (tail_q == 2'd2) ? 2'd0 : tail_q + 2'd1;
      end
      head_d = head_q;
      if (pop) begin
         head_d = (head_q == 2'd2) ? 2'd0 : head_q + 2'd1;
      end
      buf_cnt_d = buf_cnt_q + 2'(pipe_v_q) - 2'(pop);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         ram_cnt_q <= '0;
         pipe_v_q  <= 1'b0;
         head_q    <= '0;
         tail_q    <= '0;
         buf_cnt_q <= '0;
         for (int unsigned i = 0; i < 3; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         ram_cnt_q <= ram_cnt_d;
         pipe_v_q  <= pipe_v_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         buf_cnt_q <= buf_cnt_d;
         buf_q     <= buf_d;
      end
   end

`ifdef RAM2_FIFO_CNT_EN
   logic [AWIDTH+1:0] fifo_cnt_q, fifo_cnt_d;

   always_comb begin
      fifo_cnt_d = (AWIDTH+2)'(ram_cnt_d) + (AWIDTH+2)'(pipe_v_d) + (AWIDTH+2)'(buf_cnt_d);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fifo_cnt_q <= '0;
      end else begin
         fifo_cnt_q <= fifo_cnt_d;
      end
   end

   assign fifo_cnt = fifo_cnt_q;
`endif

endmodule

// File: tb/tb_ram2_fifo_ctrl.sv
// Bench for ram2_fifo_ctrl (AWIDTH=3): a word-queue reference model checked every cycle plus directed literal checks.
module tb_ram2_fifo_ctrl;
   localparam int DW    = 16;
   localparam int AW    = 3;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] din;
   logic          din_valid;
   logic          din_ready;
   logic [DW-1:0] dout;
   logic          dout_valid;
   logic          dout_ready;
   logic          wrena;
   logic [AW-1:0] wraddra;
   logic [DW-1:0] dia;
   logic          rdena;
   logic [AW-1:0] rdaddra;
   logic [DW-1:0] doa = '0;
   logic          full;
   logic          empty;
`ifdef RAM2_FIFO_CNT_EN
   logic [AW+1:0] fifo_cnt;
`endif

   ram2_fifo_ctrl #(.DWIDTH(DW), .AWIDTH(AW)) dut (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .wrena(wrena), .wraddra(wraddra), .dia(dia), .rdena(rdena), .rdaddra(rdaddra),
      .doa(doa), .full(full),
`ifdef RAM2_FIFO_CNT_EN
      .fifo_cnt(fifo_cnt),
`endif
      .empty(empty)
   );

   always #5 clk = ~clk;

   // ram2 port A stand-in: registered read, one cycle latency
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (wrena) mem[wraddra] <= dia;
      if (rdena) doa <= mem[rdaddra];
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: words accepted but not yet delivered, reads issued but not yet delivered
   logic [DW-1:0] q [$];
   int            outstanding = 0;
   bit            last_rd = 0;
   int            wr_n = 0, rd_n = 0, pops = 0, cyc = 0;
   logic [DW-1:0] last_popped = '0;
   bit            prev_stall = 0;
   logic [DW-1:0] prev_dout = '0;
   int            acc_cyc [$];
   int            pop_cyc [$];
   logic [DW-1:0] pop_dat [$];

   always @(negedge clk) begin
      int  ram_words;
      bit  exp_full, exp_wr, exp_rd, exp_valid, exp_pop;
      cyc++;
      if (reset) begin
         chk("rst_wrena", wrena, din_valid & 1'b1);
         chk("rst_rdena", rdena, 0);
         chk("rst_dout_valid", dout_valid, 0);
         chk("rst_din_ready", din_ready, 1);
         chk("rst_full", full, 0);
         chk("rst_empty", empty, 1);
         chk("rst_dout", dout, 0);
`ifdef RAM2_FIFO_CNT_EN
         chk("rst_fifo_cnt", fifo_cnt, 0);
`endif
         q.delete();
         outstanding = 0; last_rd = 0; wr_n = 0; rd_n = 0; prev_stall = 0;
      end else begin
         ram_words = q.size() - outstanding;
         exp_full  = (ram_words == DEPTH);
         exp_wr    = din_valid && !exp_full;
         exp_rd    = (ram_words > 0) && (outstanding < 3);
         exp_valid = (outstanding - int'(last_rd)) > 0;
         exp_pop   = exp_valid && dout_ready;
         chk("full", full, exp_full);
         chk("din_ready", din_ready, !exp_full);
         chk("wrena", wrena, exp_wr);
         chk("dia", dia, din);
         chk("rdena", rdena, exp_rd);
         chk("dout_valid", dout_valid, exp_valid);
         chk("empty", empty, q.size() == 0);
         if (exp_wr) chk("wraddra", wraddra, wr_n % DEPTH);
         if (exp_rd) chk("rdaddra", rdaddra, rd_n % DEPTH);
         if (exp_valid) chk("dout", dout, q[0]);
`ifdef RAM2_FIFO_CNT_EN
         chk("fifo_cnt", fifo_cnt, q.size());
`endif
         if (prev_stall) begin
            chk("stall_valid", dout_valid, 1);
            chk("stall_dout", dout, prev_dout);
         end
         prev_stall = exp_valid && !dout_ready;
         prev_dout  = dout;
         if (exp_wr) begin
            q.push_back(din);
            wr_n++;
            acc_cyc.push_back(cyc);
         end
         if (exp_rd) begin
            outstanding++;
            rd_n++;
         end
         if (exp_pop) begin
            last_popped = q.pop_front();
            outstanding--;
            pops++;
            pop_cyc.push_back(cyc);
            pop_dat.push_back(last_popped);
         end
         last_rd = exp_rd;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      acc_cyc.delete();
      pop_cyc.delete();
      pop_dat.delete();
   endtask

   task automatic drain(input string name);
      din_valid  = 1'b0;
      dout_ready = 1'b1;
      repeat (20) step();
      chk(name, empty, 1);
   endtask

   initial begin
      int start;
      int budget;
      reset = 1'b1; din = '0; din_valid = 1'b0; dout_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // short burst: latency and order
      clear_logs();
      dout_ready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         din = 16'(i); din_valid = 1'b1; step();
      end
      din_valid = 1'b0;
      repeat (10) step();
      chk("t1_accepts", acc_cyc.size(), 5);
      chk("t1_pops", pop_cyc.size(), 5);
      if (acc_cyc.size() == 5 && pop_cyc.size() == 5) begin
         for (int i = 0; i < 5; i++) begin
            chk("t1_acc_cycle", acc_cyc[i] - acc_cyc[0], i);
            chk("t1_out_cycle", pop_cyc[i] - acc_cyc[0], 3 + i);
            chk("t1_data", pop_dat[i], i + 1);
         end
      end
      chk("t1_empty", empty, 1);

      // fill with consumer stalled
      clear_logs();
      dout_ready = 1'b0; din_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         din = 16'h0100 + 16'(i); step();
      end
      chk("t2_accepts", acc_cyc.size(), 11);
      chk("t2_full", full, 1);
      chk("t2_din_ready", din_ready, 0);
`ifdef RAM2_FIFO_CNT_EN
      chk("t2_fifo_cnt", fifo_cnt, 11);
`endif

      // full to streaming across pointer wrap
      clear_logs();
      dout_ready = 1'b1;
      for (int i = 0; i < 60; i++) begin
         din = 16'h0200 + 16'(i); step();
      end
      chk("t3_pops_ge40", pop_cyc.size() >= 40, 1);
      chk("t3_first_out", pop_dat.size() > 0 ? pop_dat[0] : 16'hxxxx, 16'h0100);
      drain("t3_empty");

      // random traffic
      start = pops; budget = 0;
      while (pops - start < 10000 && budget < 60000) begin
         din_valid  = 1'($urandom_range(1));
         dout_ready = 1'($urandom_range(1));
         din        = 16'($urandom);
         step();
         budget++;
      end
      chk("t4_words_done", pops - start >= 10000, 1);
      drain("t4_empty");

      // reset with 6 words held and a read in flight
      dout_ready = 1'b0; din_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         din = 16'h0300 + 16'(i); step();
      end
      din_valid = 1'b0; dout_ready = 1'b1; step();
      dout_ready = 1'b0; step();
      chk("t5_held_words", q.size(), 6);
      chk("t5_read_inflight", last_rd, 1);
      reset = 1'b1;
      @(negedge clk); #1;
      chk("t5_rst_dout_valid", dout_valid, 0);
      chk("t5_rst_rdena", rdena, 0);
      chk("t5_rst_empty", empty, 1);
      chk("t5_rst_dout", dout, 0);
      chk("t5_rst_din_ready", din_ready, 1);
      @(posedge clk); #1 reset = 1'b0;
      din = 16'hBEEF; din_valid = 1'b1; dout_ready = 1'b1;
      start = pops;
      step();
      din_valid = 1'b0;
      for (int k = 0; k < 10 && pops == start; k++) step();
      chk("t5_popped", pops > start, 1);
      chk("t5_first_word", last_popped, 16'hBEEF);
      drain("t5_empty");

      // alternating stall with complementary patterns
      for (int i = 0; i < 200; i++) begin
         din = (i % 2) ? 16'h5A5A : 16'hA5A5;
         din_valid = 1'b1;
         dout_ready = 1'(i % 2);
         step();
      end
      drain("t6_empty");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
